core_control_hazard_sb: RTL

- Parametrised scoreboard-based stall/hazard controller for the core's issue stage; successor of the single-slot hazard check.
- Tracks up to DEPTH in-flight instructions between issue and writeback. Detects register RAW, R15, flags and PSR hazards against every pending slot.
- Drives stall/bubble into the issue stage and runs a drain-then-halt FSM for debug halt.

---
 rtl/core_control_hazard_sb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/core_control_hazard_sb.sv
// Scoreboard-based stall/hazard controller for the issue stage.
// Tracks DEPTH in-flight instructions between issue and writeback.
// It checks every pending slot for register RAW, R15, flags, PSR and
// user-bank hazards. A drain-then-halt FSM serves debug halt requests.
module core_control_hazard_sb #(
  parameter int DEPTH = 2,
  parameter int NSRC  = 3,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                halt,
  input  logic                flush,
  input  logic                issue_req,
  input  logic [NSRC-1:0]     src_use,
  input  logic [NSRC*4-1:0]   src_reg,
  input  logic                dst_wb,
  input  logic [3:0]          dst_reg,
  input  logic                dst_user,
  input  logic                sets_flags,
  input  logic                reads_flags,
  input  logic                psr_write,
  output logic                stall,
  output logic                next_bubble,
  output logic                bubble,
  output logic                halted,
  output logic                busy,
  output logic [CNT_W-1:0]    stall_cycles
);

  typedef struct packed {
    logic       valid;
    logic       wb;
    logic [3:0] rd;
    logic       user;
    logic       flags;
    logic       psr;
  } slot_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  slot_t  slots [DEPTH];
  slot_t  new_slot;
  state_t state_q, state_d;

  logic raw_hz, pc_hz, flag_hz, psr_hz, user_hz;
  logic any_flags, any_valid;
  logic halt_block;
  logic fire;

  // Scan every pending slot for hazards against the issuing instruction.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path leaves it unassigned (no latch).
    raw_hz    = 1'b0;
    pc_hz     = 1'b0;
    psr_hz    = 1'b0;
    any_flags = 1'b0;
    any_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (slots[k].valid) begin
        any_valid = 1'b1;
        if (slots[k].wb && slots[k].rd == 4'd15) pc_hz = 1'b1;
        if (slots[k].flags) any_flags = 1'b1;
        if (slots[k].psr) psr_hz = 1'b1;
        for (int i = 0; i < NSRC; i++) begin
          if (src_use[i] && slots[k].wb && slots[k].rd == src_reg[4*i +: 4]) raw_hz = 1'b1;
        end
      end
    end
  end

  assign busy        = any_valid;
  assign flag_hz     = reads_flags && any_flags;
  // User-bank accesses must issue into an empty scoreboard.
  assign user_hz     = dst_user && any_valid;
  assign next_bubble = issue_req && (raw_hz | pc_hz | flag_hz | psr_hz | user_hz);
  assign halt_block  = (state_q != ST_RUN);
  assign stall       = next_bubble || !issue_req || halt_block;
  assign fire        = issue_req && !stall;
  assign halted      = (state_q == ST_HALTED);

  assign new_slot = '{valid: 1'b1, wb: dst_wb, rd: dst_reg, user: dst_user,
                      flags: sets_flags, psr: psr_write};

  // Shift the scoreboard one slot per cycle; slot 0 takes the issuing instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slots are a small flop array, not RAM; they are reset so no stale valid bit survives reset.
      for (int k = 0; k < DEPTH; k++) slots[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) slots[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every slot read its neighbour's old value, which gives a true shift.
      for (int k = DEPTH - 1; k > 0; k--) slots[k] <= slots[k-1];
      slots[0] <= fire ? new_slot : '0;
    end
  end

  // Halt FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Halt FSM next state: drain in-flight slots, then hold until halt drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (halt) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!halt)      state_d = ST_RUN;
        else if (!busy) state_d = ST_HALTED;
      end
      ST_HALTED: if (!halt) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Registered flag recording that a bubble was inserted in the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble <= 1'b0;
    else        bubble <= issue_req && next_bubble;
  end

  // Saturating count of cycles in which a waiting instruction was held back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (issue_req && stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
